// File: rtl/icache_mshr_entry_tracker_if.sv
// Handshake bundle between the MSHR entry tracker and its pre-allocator / miss path / refill
// clients. The slave modport belongs to the tracker; the master modport belongs to its users.
interface icache_mshr_entry_tracker_if #(
    parameter int unsigned ENTRY_NUM   = 8,
    parameter int unsigned INDEX_WIDTH = $clog2(ENTRY_NUM),
    parameter int unsigned CNT_WIDTH   = $clog2(ENTRY_NUM + 1)
);
    logic [ENTRY_NUM-1:0]   v_free_vld;
    logic [ENTRY_NUM-1:0]   v_rsv_oh;
    logic                   rsv_en;
    logic                   alloc_vld;
    logic [INDEX_WIDTH-1:0] alloc_idx;
    logic                   alloc_rdy;
    logic                   rel_vld;
    logic [INDEX_WIDTH-1:0] rel_idx;
    logic                   flush;
    logic [ENTRY_NUM-1:0]   v_busy;
    logic [CNT_WIDTH-1:0]   busy_cnt;
    logic                   full;
    logic                   err_illegal;

    modport master (
        input  v_free_vld, alloc_rdy, v_busy, busy_cnt, full, err_illegal,
        output v_rsv_oh, rsv_en, alloc_vld, alloc_idx, rel_vld, rel_idx, flush
    );

    modport slave (
        output v_free_vld, alloc_rdy, v_busy, busy_cnt, full, err_illegal,
        input  v_rsv_oh, rsv_en, alloc_vld, alloc_idx, rel_vld, rel_idx, flush
    );
endinterface

// File: rtl/icache_mshr_entry_tracker.sv
// Per-entry FREE -> RSV -> BUSY -> FREE lifecycle for the icache MSHRs, with reservation
// timeout/flush reclaim, a registered busy count and a sticky protocol-error flag.
module icache_mshr_entry_tracker #(
    parameter int unsigned ENTRY_NUM   = 8,
    parameter int unsigned INDEX_WIDTH = $clog2(ENTRY_NUM),
    parameter int unsigned CNT_WIDTH   = $clog2(ENTRY_NUM + 1),
    parameter int unsigned RSV_TIMEOUT = 16
) (
    input logic clk,
    input logic rst_n,
    icache_mshr_entry_tracker_if.slave io_trk
);
    // A disabled timeout still needs a legal (1-bit) age register.
    localparam int unsigned AGE_WIDTH = (RSV_TIMEOUT > 0) ? $clog2(RSV_TIMEOUT + 1) : 1;
    localparam logic [AGE_WIDTH-1:0] AGE_MAX  = '1;
    localparam logic [AGE_WIDTH-1:0] AGE_LAST =
        AGE_WIDTH'((RSV_TIMEOUT > 0) ? (RSV_TIMEOUT - 1) : 0);
    localparam bit TIMEOUT_EN = (RSV_TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_FREE = 2'b00,
        ST_RSV  = 2'b01,
        ST_BUSY = 2'b10,
        ST_BAD  = 2'b11
    } entry_st_e;

    entry_st_e            r_st      [ENTRY_NUM];
    entry_st_e            w_st_nxt  [ENTRY_NUM];
    logic [AGE_WIDTH-1:0] r_age     [ENTRY_NUM];
    logic [AGE_WIDTH-1:0] w_age_nxt [ENTRY_NUM];
    logic [CNT_WIDTH-1:0] r_busy_cnt;
    logic [CNT_WIDTH-1:0] w_busy_cnt_nxt;
    logic                 r_err;
    logic                 w_err_nxt;

    logic [ENTRY_NUM-1:0] w_is_free;
    logic [ENTRY_NUM-1:0] w_is_rsv;
    logic [ENTRY_NUM-1:0] w_is_busy;
    logic [ENTRY_NUM-1:0] w_is_bad;
    logic [ENTRY_NUM-1:0] w_alloc_dec;
    logic [ENTRY_NUM-1:0] w_rel_dec;
    logic [ENTRY_NUM-1:0] w_alloc_fire_vec;
    logic [ENTRY_NUM-1:0] w_timeout;

    logic w_rsv_onehot;
    logic w_rsv_conflict;
    logic w_rsv_ok;
    logic w_rel_ok;
    logic w_alloc_fire;
    logic w_err_set;

    always_comb begin
        for (int i = 0; i < ENTRY_NUM; i++) begin
            w_is_free[i]   = (r_st[i] == ST_FREE);
            w_is_rsv[i]    = (r_st[i] == ST_RSV);
            w_is_busy[i]   = (r_st[i] == ST_BUSY);
            w_is_bad[i]    = (r_st[i] == ST_BAD);
            w_alloc_dec[i] = (io_trk.alloc_idx == INDEX_WIDTH'(i));
            w_rel_dec[i]   = (io_trk.rel_idx == INDEX_WIDTH'(i));
            w_timeout[i]   = TIMEOUT_EN && (r_age[i] == AGE_LAST);
        end
    end

    // An index with no decode hit is out of range; that case falls out of the same vectors.
    assign w_rsv_onehot     = $onehot(io_trk.v_rsv_oh);
    assign w_rsv_conflict   = |(io_trk.v_rsv_oh & ~w_is_free);
    assign w_rsv_ok         = io_trk.rsv_en & w_rsv_onehot & ~w_rsv_conflict;
    assign w_rel_ok         = io_trk.rel_vld & |(w_rel_dec & w_is_busy);
    assign w_alloc_fire_vec = {ENTRY_NUM{io_trk.alloc_vld}} & w_alloc_dec & w_is_rsv;
    assign w_alloc_fire     = |w_alloc_fire_vec;

    assign w_err_set = (io_trk.rsv_en & (~w_rsv_onehot | w_rsv_conflict))
                     | (io_trk.rel_vld & ~w_rel_ok)
                     | (io_trk.alloc_vld & ~|w_alloc_dec)
                     | (|w_is_bad);

    always_comb begin
        for (int i = 0; i < ENTRY_NUM; i++) begin
            w_st_nxt[i]  = r_st[i];
            w_age_nxt[i] = r_age[i];
            unique case (r_st[i])
                ST_FREE: begin
                    if (w_rsv_ok && io_trk.v_rsv_oh[i]) begin
                        w_st_nxt[i]  = ST_RSV;
                        w_age_nxt[i] = '0;
                    end
                end
                ST_RSV: begin
                    // Allocation wins over both flush and timeout on the same entry.
                    if (w_alloc_fire_vec[i]) begin
                        w_st_nxt[i] = ST_BUSY;
                    end else if (io_trk.flush || w_timeout[i]) begin
                        w_st_nxt[i] = ST_FREE;
                    end else if (r_age[i] != AGE_MAX) begin
                        w_age_nxt[i] = r_age[i] + AGE_WIDTH'(1);
                    end
                end
                ST_BUSY: begin
                    if (w_rel_ok && w_rel_dec[i]) begin
                        w_st_nxt[i] = ST_FREE;
                    end
                end
                ST_BAD: begin
                    w_st_nxt[i] = ST_BAD;
                end
            endcase
        end
    end

    assign w_busy_cnt_nxt = r_busy_cnt + CNT_WIDTH'(w_alloc_fire) - CNT_WIDTH'(w_rel_ok);
    assign w_err_nxt      = r_err | w_err_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                r_st[i]  <= ST_FREE;
                r_age[i] <= '0;
            end
            r_busy_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                r_st[i]  <= w_st_nxt[i];
                r_age[i] <= w_age_nxt[i];
            end
            r_busy_cnt <= w_busy_cnt_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign io_trk.v_free_vld  = w_is_free;
    assign io_trk.v_busy      = w_is_busy;
    assign io_trk.busy_cnt    = r_busy_cnt;
    assign io_trk.full        = ~|w_is_free;
    assign io_trk.alloc_rdy   = |(w_alloc_dec & w_is_rsv);
    assign io_trk.err_illegal = r_err;
endmodule

// File: tb/tb_icache_mshr_entry_tracker.sv
// Directed and randomized checks of the MSHR entry tracker against a list-based reference model.
module tb_icache_mshr_entry_tracker;
    localparam int N  = 8;
    localparam int IW = 3;
    localparam int CW = 4;
    localparam int TO = 16;

    localparam int S_FREE = 0;
    localparam int S_RSV  = 1;
    localparam int S_BUSY = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    icache_mshr_entry_tracker_if #(.ENTRY_NUM(N), .INDEX_WIDTH(IW), .CNT_WIDTH(CW)) trk ();

    icache_mshr_entry_tracker #(
        .ENTRY_NUM(N), .INDEX_WIDTH(IW), .CNT_WIDTH(CW), .RSV_TIMEOUT(TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_trk(trk)
    );

    int m_st [N];
    int m_age[N];
    int m_cnt;
    bit m_err;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] m_vec(input int s);
        logic [N-1:0] v = '0;
        for (int i = 0; i < N; i++) if (m_st[i] == s) v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i]  = S_FREE;
            m_age[i] = 0;
        end
        m_cnt = 0;
        m_err = 1'b0;
    endtask

    task automatic check_outputs();
        int ai = int'(trk.alloc_idx);
        check("v_free_vld", 32'(trk.v_free_vld), 32'(m_vec(S_FREE)));
        check("v_busy", 32'(trk.v_busy), 32'(m_vec(S_BUSY)));
        check("busy_cnt", 32'(trk.busy_cnt), 32'(m_cnt));
        check("full", 32'(trk.full), 32'(m_vec(S_FREE) == '0));
        check("alloc_rdy", 32'(trk.alloc_rdy), 32'(ai < N && m_st[ai] == S_RSV));
        check("err_illegal", 32'(trk.err_illegal), 32'(m_err));
    endtask

    // Applies the lifecycle rules to the model using the inputs present at this edge.
    task automatic model_step();
        int  nst [N];
        int  nage[N];
        int  ri = -1;
        int  ai = int'(trk.alloc_idx);
        int  li = int'(trk.rel_idx);
        bit  rsv_ok = 1'b0;
        bit  rel_ok = 1'b0;
        bit  fire;
        if (trk.rsv_en) begin
            if ($countones(trk.v_rsv_oh) != 1) m_err = 1'b1;
            else begin
                for (int i = 0; i < N; i++) if (trk.v_rsv_oh[i]) ri = i;
                if (m_st[ri] != S_FREE) m_err = 1'b1;
                else rsv_ok = 1'b1;
            end
        end
        if (trk.rel_vld) begin
            if (li >= N || m_st[li] != S_BUSY) m_err = 1'b1;
            else rel_ok = 1'b1;
        end
        if (trk.alloc_vld && ai >= N) m_err = 1'b1;
        fire = trk.alloc_vld && ai < N && m_st[ai] == S_RSV;
        for (int i = 0; i < N; i++) begin
            nst[i]  = m_st[i];
            nage[i] = m_age[i];
            if (m_st[i] == S_FREE && rsv_ok && ri == i) begin
                nst[i]  = S_RSV;
                nage[i] = 0;
            end else if (m_st[i] == S_RSV) begin
                if (fire && ai == i) nst[i] = S_BUSY;
                else if (trk.flush || (TO != 0 && m_age[i] == TO - 1)) nst[i] = S_FREE;
                else if (m_age[i] < TO) nage[i] = m_age[i] + 1;
            end else if (m_st[i] == S_BUSY && rel_ok && li == i) begin
                nst[i] = S_FREE;
            end
        end
        m_st  = nst;
        m_age = nage;
        m_cnt = m_cnt + int'(fire) - int'(rel_ok);
    endtask

    task automatic idle();
        trk.rsv_en    = 1'b0;
        trk.v_rsv_oh  = '0;
        trk.alloc_vld = 1'b0;
        trk.alloc_idx = '0;
        trk.rel_vld   = 1'b0;
        trk.rel_idx   = '0;
        trk.flush     = 1'b0;
    endtask

    // Called just after a negedge with inputs already set; returns just after the next negedge.
    task automatic step();
        #1;
        check_outputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic reserve(input int i);
        idle();
        trk.rsv_en   = 1'b1;
        trk.v_rsv_oh = N'(1) << i;
        step();
    endtask

    task automatic alloc(input int i);
        idle();
        trk.alloc_vld = 1'b1;
        trk.alloc_idx = IW'(i);
        step();
    endtask

    task automatic rand_inputs(input bit allow_err);
        int q[$];
        idle();
        if (allow_err && $urandom_range(9) == 0) begin
            trk.rsv_en    = 1'($urandom);
            trk.v_rsv_oh  = N'($urandom);
            trk.alloc_vld = 1'($urandom);
            trk.alloc_idx = IW'($urandom);
            trk.rel_vld   = 1'($urandom);
            trk.rel_idx   = IW'($urandom);
            trk.flush     = 1'($urandom_range(7) == 0);
            return;
        end
        if ($urandom_range(99) < 40) begin
            q.delete();
            for (int i = 0; i < N; i++) if (m_st[i] == S_FREE) q.push_back(i);
            if (q.size() > 0) begin
                trk.rsv_en   = 1'b1;
                trk.v_rsv_oh = N'(1) << q[$urandom_range(q.size() - 1)];
            end
        end
        q.delete();
        for (int i = 0; i < N; i++) if (m_st[i] == S_RSV) q.push_back(i);
        trk.alloc_idx = IW'($urandom_range(N - 1));
        if ($urandom_range(99) < 50) begin
            trk.alloc_vld = 1'b1;
            if (q.size() > 0 && $urandom_range(3) != 0)
                trk.alloc_idx = IW'(q[$urandom_range(q.size() - 1)]);
        end
        if ($urandom_range(99) < 30) begin
            q.delete();
            for (int i = 0; i < N; i++) if (m_st[i] == S_BUSY) q.push_back(i);
            if (q.size() > 0) begin
                trk.rel_vld = 1'b1;
                trk.rel_idx = IW'(q[$urandom_range(q.size() - 1)]);
            end
        end
        if ($urandom_range(99) < 3) trk.flush = 1'b1;
    endtask

    initial begin
        idle();
        model_reset();
        @(negedge clk);

        // Reset state, then reserve and allocate entry 0.
        do_reset();
        check("rst_free", 32'(trk.v_free_vld), 32'h00FF);
        check("rst_rdy", 32'(trk.alloc_rdy), 32'h0);
        reserve(0);
        idle();
        check("rsv0_free", 32'(trk.v_free_vld), 32'h00FE);
        trk.alloc_vld = 1'b1;
        #1;
        check("alloc0_rdy", 32'(trk.alloc_rdy), 32'h1);
        step();
        idle();
        check("alloc0_busy", 32'(trk.v_busy), 32'h01);
        check("alloc0_cnt", 32'(trk.busy_cnt), 32'h1);

        // Timeout reclaim exactly 16 edges after the reserve edge.
        do_reset();
        reserve(3);
        idle();
        for (int k = 0; k < TO - 1; k++) step();
        check("to_hold", 32'(trk.v_free_vld), 32'h00F7);
        step();
        check("to_reclaim", 32'(trk.v_free_vld), 32'h00FF);

        // Allocation on the 15th edge beats the timeout.
        do_reset();
        reserve(3);
        idle();
        for (int k = 0; k < TO - 2; k++) step();
        alloc(3);
        idle();
        for (int k = 0; k < 5; k++) step();
        check("to_alloc_busy", 32'(trk.v_busy), 32'h08);

        // All entries busy, then release entry 5.
        do_reset();
        for (int i = 0; i < N; i++) begin
            reserve(i);
            alloc(i);
        end
        idle();
        check("all_full", 32'(trk.full), 32'h1);
        check("all_cnt", 32'(trk.busy_cnt), 32'h8);
        trk.rel_vld = 1'b1;
        trk.rel_idx = IW'(5);
        step();
        idle();
        check("rel5_cnt", 32'(trk.busy_cnt), 32'h7);
        check("rel5_free", 32'(trk.v_free_vld), 32'h20);
        check("rel5_full", 32'(trk.full), 32'h0);

        // Alloc, release, reserve and flush all in the same cycle.
        do_reset();
        reserve(1);
        reserve(2);
        reserve(4);
        alloc(4);
        trk.alloc_vld = 1'b1;
        trk.alloc_idx = IW'(2);
        trk.rel_vld   = 1'b1;
        trk.rel_idx   = IW'(4);
        trk.rsv_en    = 1'b1;
        trk.v_rsv_oh  = 8'h40;
        trk.flush     = 1'b1;
        step();
        idle();
        trk.alloc_idx = IW'(6);
        #1;
        check("multi_busy", 32'(trk.v_busy), 32'h04);
        check("multi_free", 32'(trk.v_free_vld), 32'hBB);
        check("multi_cnt", 32'(trk.busy_cnt), 32'h1);
        check("multi_rdy6", 32'(trk.alloc_rdy), 32'h1);
        step();

        // Protocol errors: each is sticky and leaves entry states alone.
        do_reset();
        trk.rel_vld = 1'b1;
        step();
        idle();
        step();
        check("err_rel_free", 32'(trk.err_illegal), 32'h1);
        check("err_rel_state", 32'(trk.v_free_vld), 32'hFF);
        do_reset();
        trk.rsv_en   = 1'b1;
        trk.v_rsv_oh = 8'h03;
        step();
        idle();
        step();
        check("err_multihot", 32'(trk.err_illegal), 32'h1);
        check("err_mh_state", 32'(trk.v_free_vld), 32'hFF);
        do_reset();
        reserve(2);
        alloc(2);
        reserve(2);
        idle();
        step();
        check("err_rsv_busy", 32'(trk.err_illegal), 32'h1);
        check("err_rb_state", 32'(trk.v_busy), 32'h04);

        // Asynchronous reset with 4 BUSY and 2 RSV entries in flight.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            reserve(i);
            alloc(i);
        end
        reserve(4);
        reserve(5);
        idle();
        trk.alloc_idx = IW'(4);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_free", 32'(trk.v_free_vld), 32'hFF);
        check("arst_cnt", 32'(trk.busy_cnt), 32'h0);
        check("arst_rdy", 32'(trk.alloc_rdy), 32'h0);
        @(negedge clk);
        do_reset();

        // Randomized legal traffic.
        for (int k = 0; k < 1500; k++) begin
            rand_inputs(1'b0);
            step();
        end

        // Randomized traffic with occasional protocol violations.
        for (int r = 0; r < 12; r++) begin
            do_reset();
            for (int k = 0; k < 60; k++) begin
                rand_inputs(1'b1);
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
